// File: rtl/fc_ifmap_rd_ctrl.sv
// Read-side sequencer for the FC ifmap buffer: walks a (wrapping) address window for one or more
// passes and streams the RAM bytes out through a 2-entry FIFO that the read credits never overflow.
module fc_ifmap_rd_ctrl #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 8,
   parameter int LEN_W  = 8,
   parameter int PASS_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] base_i,
   input  logic [LEN_W-1:0]  len_i,
   input  logic [PASS_W-1:0] passes_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              rden_o,
   output logic [ADDR_W-1:0] rdptr_o,
   input  logic [DATA_W-1:0] ifmap_i,
   output logic [DATA_W-1:0] ifmap_o,
   output logic              valid_o,
   input  logic              ready_i,
   output logic              last_o,
   output logic [1:0]        state_dbg_o
);

   localparam logic [LEN_W-1:0] DEPTH = LEN_W'(2**ADDR_W);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  byte_q, byte_d;
   logic [PASS_W-1:0] passes_q, passes_d;
   logic [PASS_W-1:0] pass_q, pass_d;

   logic              rden_q;
   logic [ADDR_W-1:0] rdptr_q;
   logic              rd_last_q;
   logic              arr_q;
   logic              arr_last_q;

   logic              issue;
   logic              issue_last;
   logic [ADDR_W-1:0] issue_addr;

   logic [DATA_W:0]   fifo_mem [2];
   logic              wr_idx_q;
   logic              rd_idx_q;
   logic [1:0]        cnt_q, cnt_d;
   logic              pop;
   logic              pop_fifo;
   logic              push;
   logic [2:0]        credit_use;

   // Stream handshake: a byte transfers on any cycle with valid_o & ready_i; while valid_o is
   // high and ready_i low, ifmap_o/last_o hold the same head entry. The head is either the
   // oldest stored entry or, when storage is empty, the RAM word arriving this cycle (arr_q).
   always_comb begin
      valid_o = (cnt_q != 2'd0) | arr_q;
      if (cnt_q != 2'd0) begin
         ifmap_o = fifo_mem[rd_idx_q][DATA_W-1:0];
         last_o  = fifo_mem[rd_idx_q][DATA_W];
      end else if (arr_q) begin
         ifmap_o = ifmap_i;
         last_o  = arr_last_q;
      end else begin
         ifmap_o = '0;
         last_o  = 1'b0;
      end
      pop        = valid_o & ready_i;
      pop_fifo   = pop & (cnt_q != 2'd0);
      push       = arr_q & ~(pop & (cnt_q == 2'd0));
      cnt_d      = cnt_q + {1'b0, push} - {1'b0, pop_fifo};
      credit_use = {1'b0, cnt_d} + {2'b00, rden_q};
   end

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      len_d      = len_q;
      passes_d   = passes_q;
      byte_d     = byte_q;
      pass_d     = pass_q;
      issue      = 1'b0;
      issue_last = 1'b0;
      issue_addr = rdptr_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               if (len_i == '0 || passes_i == '0) begin
                  state_d = DONE;
               end else begin
                  base_d   = base_i;
                  len_d    = (len_i > DEPTH) ? DEPTH : len_i;
                  passes_d = passes_i;
                  byte_d   = '0;
                  pass_d   = '0;
                  state_d  = RUN;
                  issue    = 1'b1;
               end
            end
         end
         RUN:     issue = (credit_use < 3'd2);
         DRAIN:   if (cnt_d == 2'd0 && !rden_q) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Shared issue path: the first read goes out with the accepted start itself.
      if (issue) begin
         issue_addr = base_d + byte_d[ADDR_W-1:0];
         if (byte_d + LEN_W'(1) == len_d) begin
            issue_last = 1'b1;
            byte_d     = '0;
            pass_d     = pass_d + PASS_W'(1);
            if (pass_d == passes_d) state_d = DRAIN;
         end else begin
            byte_d = byte_d + LEN_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         base_q      <= '0;
         len_q       <= '0;
         passes_q    <= '0;
         byte_q      <= '0;
         pass_q      <= '0;
         rden_q      <= 1'b0;
         rdptr_q     <= '0;
         rd_last_q   <= 1'b0;
         arr_q       <= 1'b0;
         arr_last_q  <= 1'b0;
         fifo_mem[0] <= '0;
         fifo_mem[1] <= '0;
         wr_idx_q    <= 1'b0;
         rd_idx_q    <= 1'b0;
         cnt_q       <= 2'd0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         len_q      <= len_d;
         passes_q   <= passes_d;
         byte_q     <= byte_d;
         pass_q     <= pass_d;
         rden_q     <= issue;
         rd_last_q  <= issue_last;
         if (issue) rdptr_q <= issue_addr;
         arr_q      <= rden_q;
         arr_last_q <= rd_last_q;
         if (push) begin
            fifo_mem[wr_idx_q] <= {arr_last_q, ifmap_i};
            wr_idx_q           <= ~wr_idx_q;
         end
         if (pop_fifo) rd_idx_q <= ~rd_idx_q;
         cnt_q <= cnt_d;
      end
   end

   assign rden_o      = rden_q;
   assign rdptr_o     = rdptr_q;
   assign busy_o      = (state_q == RUN) || (state_q == DRAIN);
   assign done_o      = (state_q == DONE);
   assign state_dbg_o = state_q;

endmodule

// File: tb/tb_fc_ifmap_rd_ctrl.sv
// Bench for fc_ifmap_rd_ctrl: RAM model, run-level reference of the expected byte stream, and a
// per-cycle compare process, plus literal latency/sequence checks for directed runs.
module tb_fc_ifmap_rd_ctrl;
   localparam int ADDR_W = 7;
   localparam int DATA_W = 8;
   localparam int LEN_W  = 8;
   localparam int PASS_W = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start_i = 1'b0;
   logic [ADDR_W-1:0] base_i = '0;
   logic [LEN_W-1:0]  len_i = '0;
   logic [PASS_W-1:0] passes_i = '0;
   logic              busy_o, done_o, rden_o, valid_o, last_o;
   logic [ADDR_W-1:0] rdptr_o;
   logic [DATA_W-1:0] ifmap_i = '0;
   logic [DATA_W-1:0] ifmap_o;
   logic              ready_i = 1'b1;
   logic [1:0]        state_dbg_o;

   fc_ifmap_rd_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .PASS_W(PASS_W)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .base_i(base_i), .len_i(len_i),
      .passes_i(passes_i), .busy_o(busy_o), .done_o(done_o), .rden_o(rden_o),
      .rdptr_o(rdptr_o), .ifmap_i(ifmap_i), .ifmap_o(ifmap_o), .valid_o(valid_o),
      .ready_i(ready_i), .last_o(last_o), .state_dbg_o(state_dbg_o)
   );

   // clock / reset / RAM
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [DATA_W-1:0] ram [128];
   always @(posedge clk) if (rden_o) ifmap_i <= ram[rdptr_o];

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // scoreboard / reference model
   logic [ADDR_W-1:0] exp_addr_q [$];
   logic [DATA_W-1:0] exp_q [$];
   logic              exp_last_q [$];
   bit                m_idle = 1'b1;
   int                done_cyc = -1;
   int                s_cyc = 0;
   int                n_rden = 0, n_xfer = 0, n_last = 0, n_done = 0;
   int                first_valid_rel = -1, done_rel = -1;
   int                obs_addr [$];
   int                obs_rden_rel [$];
   bit                prev_stall = 1'b0;
   logic [DATA_W-1:0] prev_data;
   logic              prev_last;
   int                m_len, m_addr;
   bit                exp_done;
   logic [ADDR_W-1:0] e_addr;
   logic [DATA_W-1:0] e_data;
   logic              e_last;

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_rden", rden_o, 0);
         chk("rst_valid", valid_o, 0);
         chk("rst_busy", busy_o, 0);
         chk("rst_done", done_o, 0);
         chk("rst_last", last_o, 0);
         chk("rst_ifmap", ifmap_o, 0);
         chk("rst_rdptr", rdptr_o, 0);
         chk("rst_state", state_dbg_o, 0);
         exp_addr_q.delete();
         exp_q.delete();
         exp_last_q.delete();
         m_idle     = 1'b1;
         done_cyc   = -1;
         prev_stall = 1'b0;
      end else begin
         chk("rden_unexpected", rden_o && exp_addr_q.size() == 0, 0);
         if (rden_o && exp_addr_q.size() != 0) begin
            e_addr = exp_addr_q.pop_front();
            chk("rdptr", rdptr_o, e_addr);
            n_rden++;
            obs_addr.push_back(int'(rdptr_o));
            obs_rden_rel.push_back(cyc - s_cyc);
            chk("outstanding_le2", (n_rden - n_xfer) <= 2, 1);
         end
         chk("valid_unexpected", valid_o && exp_q.size() == 0, 0);
         if (prev_stall) begin
            chk("stall_valid", valid_o, 1);
            chk("stall_data", ifmap_o, prev_data);
            chk("stall_last", last_o, prev_last);
         end
         if (valid_o && first_valid_rel < 0) first_valid_rel = cyc - s_cyc;
         if (valid_o && ready_i && exp_q.size() != 0) begin
            e_data = exp_q.pop_front();
            e_last = exp_last_q.pop_front();
            chk("data", ifmap_o, e_data);
            chk("last", last_o, e_last);
            n_xfer++;
            if (last_o) n_last++;
            if (exp_q.size() == 0) done_cyc = cyc + 1;
         end
         prev_stall = valid_o && !ready_i;
         prev_data  = ifmap_o;
         prev_last  = last_o;
         exp_done = !m_idle && (cyc == done_cyc);
         chk("done", done_o, exp_done);
         chk("busy", busy_o, !m_idle && !exp_done);
         if (done_o) begin
            n_done++;
            done_rel = cyc - s_cyc;
         end
         // start acceptance: only an idle block takes a command
         if (m_idle) begin
            if (start_i) begin
               s_cyc = cyc;
               m_idle = 1'b0;
               done_cyc = -1;
               n_rden = 0; n_xfer = 0; n_last = 0; n_done = 0;
               first_valid_rel = -1; done_rel = -1;
               obs_addr.delete();
               obs_rden_rel.delete();
               if (len_i == 0 || passes_i == 0) begin
                  done_cyc = cyc + 1;
               end else begin
                  m_len = (int'(len_i) > 128) ? 128 : int'(len_i);
                  for (int p = 0; p < int'(passes_i); p++) begin
                     for (int b = 0; b < m_len; b++) begin
                        m_addr = (int'(base_i) + b) % 128;
                        exp_addr_q.push_back(ADDR_W'(m_addr));
                        exp_q.push_back(ram[m_addr]);
                        exp_last_q.push_back(b == m_len - 1);
                     end
                  end
               end
            end
         end else if (cyc == done_cyc) begin
            m_idle = 1'b1;
         end
      end
   end

   // driver tasks
   task automatic check_zero_now();
      chk("async_rden", rden_o, 0);
      chk("async_valid", valid_o, 0);
      chk("async_busy", busy_o, 0);
      chk("async_done", done_o, 0);
      chk("async_ifmap", ifmap_o, 0);
      chk("async_rdptr", rdptr_o, 0);
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1;
      start_i = 1'b0;
      rst = 1'b1;
      #1;
      check_zero_now();
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic do_start(input int b, input int l, input int p);
      @(posedge clk); #1;
      base_i   = ADDR_W'(b);
      len_i    = LEN_W'(l);
      passes_i = PASS_W'(p);
      ready_i  = 1'b1;
      start_i  = 1'b1;
      @(posedge clk); #1;
      start_i  = 1'b0;
   endtask

   task automatic wait_done(input int mode, input int lo_a, input int lo_b, input bit extra);
      int rel;
      for (int k = 0; k < 3000; k++) begin
         start_i = 1'b0;
         if (m_idle) return;
         rel = cyc - s_cyc;
         case (mode)
            0:       ready_i = 1'b1;
            1:       ready_i = ($urandom_range(0, 3) != 0);
            default: ready_i = !(rel >= lo_a && rel <= lo_b);
         endcase
         if (extra && (rel == 3 || rel == 5)) begin
            base_i   = 7'd99;
            len_i    = 8'd5;
            passes_i = 4'd1;
            start_i  = 1'b1;
         end
         @(posedge clk); #1;
      end
      start_i = 1'b0;
      chk("run_timeout", 1, 0);
      pulse_reset();
   endtask

   task automatic run(input int b, input int l, input int p, input int mode,
                      input int lo_a, input int lo_b, input bit extra);
      do_start(b, l, p);
      wait_done(mode, lo_a, lo_b, extra);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 128; i++) ram[i] = 8'(i);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);

      // base 0, len 4, one pass, full-rate sink
      run(0, 4, 1, 0, 0, 0, 1'b0);
      chk("t1_first_rden_rel", obs_rden_rel.size() > 0 ? obs_rden_rel[0] : -1, 1);
      chk("t1_first_valid_rel", first_valid_rel, 2);
      chk("t1_done_rel", done_rel, 6);
      chk("t1_n_rden", n_rden, 4);
      chk("t1_addr3", obs_addr.size() > 3 ? obs_addr[3] : -1, 3);
      chk("t1_n_last", n_last, 1);

      // wrap-around window
      run(124, 8, 1, 0, 0, 0, 1'b0);
      chk("t2_addr3", obs_addr.size() > 3 ? obs_addr[3] : -1, 127);
      chk("t2_addr4", obs_addr.size() > 4 ? obs_addr[4] : -1, 0);
      chk("t2_addr7", obs_addr.size() > 7 ? obs_addr[7] : -1, 3);
      chk("t2_n_last", n_last, 1);

      // three passes of a 3-byte window
      run(10, 3, 3, 0, 0, 0, 1'b0);
      chk("t3_n_xfer", n_xfer, 9);
      chk("t3_n_last", n_last, 3);
      chk("t3_n_done", n_done, 1);
      chk("t3_addr3", obs_addr.size() > 3 ? obs_addr[3] : -1, 10);

      // back-pressure window
      run(0, 6, 1, 2, 2, 7, 1'b0);
      chk("t4_n_xfer", n_xfer, 6);
      chk("t4_rden1_rel", obs_rden_rel.size() > 1 ? obs_rden_rel[1] : -1, 2);
      chk("t4_rden2_rel", obs_rden_rel.size() > 2 ? obs_rden_rel[2] : -1, 9);

      // empty commands
      run(3, 0, 2, 0, 0, 0, 1'b0);
      chk("t5_len0_n_rden", n_rden, 0);
      chk("t5_len0_done_rel", done_rel, 1);
      run(3, 5, 0, 0, 0, 0, 1'b0);
      chk("t5_pass0_n_rden", n_rden, 0);
      chk("t5_pass0_done_rel", done_rel, 1);

      // oversize length clamps to the buffer depth
      run(5, 200, 1, 1, 0, 0, 1'b0);
      chk("t6_n_xfer", n_xfer, 128);
      chk("t6_n_last", n_last, 1);
      chk("t6_addr127", obs_addr.size() > 127 ? obs_addr[127] : -1, 4);

      // async reset mid-run, then a fresh run with stray starts while busy
      do_start(20, 10, 2);
      for (int k = 0; k < 100; k++) begin
         if (n_xfer >= 3) break;
         @(posedge clk); #1;
      end
      chk("t7_xfers_before_rst", n_xfer, 3);
      rst = 1'b1;
      #1;
      check_zero_now();
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      run(50, 12, 2, 1, 0, 0, 1'b1);
      chk("t7_addr0", obs_addr.size() > 0 ? obs_addr[0] : -1, 50);
      chk("t7_n_xfer", n_xfer, 24);
      chk("t7_n_done", n_done, 1);

      // randomized runs
      for (int r = 0; r < 14; r++) begin
         run($urandom_range(0, 127), $urandom_range(1, 20), $urandom_range(1, 3),
             1, 0, 0, 1'b0);
      end
      for (int r = 0; r < 3; r++) begin
         run($urandom_range(0, 127), $urandom_range(0, 255), $urandom_range(0, 2),
             1, 0, 0, 1'b0);
      end

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fc_ifmap_rd_ctrl.md
Name: fc_ifmap_rd_ctrl

Overview:
Read-side sequencer for the FC ifmap buffer, a 128 x 8-bit RAM with one-cycle registered read. After a start command it walks a window of the buffer, optionally repeating the pass for reuse across output neurons. It drives the RAM read port (rden/rdptr) and delivers bytes on a valid/ready stream to the FC PE array, with a 2-entry output FIFO so back-pressure never drops RAM data.

Parameters:
ADDR_W, 7, RAM address width; depth = 2**ADDR_W = 128
DATA_W, 8, ifmap element width
LEN_W, 8, width of len_i; holds 0..128
PASS_W, 4, width of passes_i; 0..15 passes

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
start_i  in  1  one-cycle command pulse; sampled only in IDLE
base_i  in  ADDR_W  first address of window, sampled with start_i
len_i  in  LEN_W  bytes per pass, sampled with start_i; values >128 clamp to 128
passes_i  in  PASS_W  number of passes, sampled with start_i
busy_o  out  1  high from cycle after accepted start until the cycle done_o pulses
done_o  out  1  one-cycle pulse after the final byte handshake
rden_o  out  1  RAM read enable
rdptr_o  out  ADDR_W  RAM read address
ifmap_i  in  DATA_W  RAM read data, valid the cycle after rden_o
ifmap_o  out  DATA_W  stream data (FIFO head)
valid_o  out  1  stream valid
ready_i  in  1  stream ready; transfer when valid_o & ready_i
last_o  out  1  high with the final byte of each pass

Behaviour:
- Reset: state IDLE. busy_o, done_o, rden_o, valid_o, last_o = 0. rdptr_o, ifmap_o = 0. FIFO, in-flight flag and counters cleared. Reset mid-run aborts immediately. No done_o is issued. The RAM is untouched.
- FSM IDLE -> RUN on start_i when len_i != 0 and passes_i != 0. Latch base, clamped len, passes. Set byte_cnt = 0 and pass_cnt = 0.
- IDLE -> DONE on start_i with len_i == 0 or passes_i == 0. No reads are issued, and done_o pulses on the next cycle.
- RUN: issue a read (rden_o = 1, rdptr_o = (base + byte_cnt) mod 128) when fifo_count + inflight < 2 and reads remain.
  - Each issued read increments byte_cnt.
  - When byte_cnt reaches len: byte_cnt returns to 0 and pass_cnt increments.
  - After the last read of the last pass, go to DRAIN.
- DRAIN: no reads. Wait until the FIFO is empty and nothing is in flight, then go to DONE.
- DONE: done_o = 1 for one cycle, then IDLE. busy_o is 0 in IDLE and DONE.
- rden_o is a registered output. rdptr_o holds its last value when rden_o = 0.
- Read data: ifmap_i is captured into the FIFO the cycle after rden_o. The last flag is computed at issue time and travels with the data.
- FIFO rules:
  - Push and pop may occur in the same cycle.
  - The credit rule guarantees the FIFO never overflows.
  - valid_o = FIFO non-empty.
  - ifmap_o and last_o show the head entry and stay stable while valid_o & !ready_i.
- Latency with ready_i held at 1:
  - start sampled at cycle 0.
  - First rden_o at cycle 1.
  - First valid_o at cycle 2.
  - Sustained rate is 1 byte per cycle.
  - done_o comes 1 cycle after the final transfer.
- Wrap-around: addresses wrap modulo 128. For example, base = 120 with len = 16 reads 120..127 and then 0..7.
- Start while busy: ignored, with no effect on the run in progress.
- ready_i low: reads stop once two credits are used. Read order and data are preserved.

Test Plan:
- RAM[i] = i, start with base = 0, len = 4, passes = 1, ready_i = 1 -> rden at cycles 1..4 with rdptr 0,1,2,3; ifmap_o 0,1,2,3 at cycles 2..5; last_o with byte 3; done_o at cycle 6; busy_o high cycles 1..5.
- base = 124, len = 8, passes = 1 -> rdptr sequence 124,125,126,127,0,1,2,3; data matches in order; last_o only on address 3.
- base = 10, len = 3, passes = 3 -> stream 10,11,12 repeated three times; last_o on each 12; single done_o after the 9th transfer.
- Back-pressure: len = 6, ready_i low for cycles 2..7 -> at most 2 reads outstanding; rden_o held low once credits exhausted; no byte lost or duplicated; ifmap_o stable while stalled; full sequence 0..5 delivered.
- len = 0 (and separately passes = 0) -> no rden_o pulse; done_o at cycle 1. len = 200 clamps to 128 bytes.
- Async rst asserted mid-run after 3 transfers -> all outputs 0 immediately; new start then runs normally from the new base; extra start_i pulses during busy ignored.
